// File: rtl/test_status_sequencer.sv
// Test-control sequencer: holds the DUT in reset for a fixed window, runs it under a
// cycle budget, and round-robin collects pass/fail reports into one sticky final status.
module test_status_sequencer #(
  parameter int NUM_SRC      = 4,
  parameter int RESET_CYCLES = 16,
  parameter int CNT_W        = 64,
  parameter int CODE_W       = 8,
  localparam int SRC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [CNT_W-1:0]           max_cycles,
  output logic                       dut_reset,
  input  logic [NUM_SRC-1:0]         rpt_valid,
  input  logic [NUM_SRC*CODE_W-1:0]  rpt_code,
  output logic [NUM_SRC-1:0]         rpt_ready,
  output logic [CNT_W-1:0]           cycle_count,
  output logic                       done,
  output logic                       success,
  output logic                       failure,
  output logic [1:0]                 reason,
  output logic [SRC_W-1:0]           fail_src,
  output logic [CODE_W-1:0]          fail_code
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [1:0] REASON_NONE    = 2'd0;
  localparam logic [1:0] REASON_TIMEOUT = 2'd1;
  localparam logic [1:0] REASON_FAIL    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state;
  logic [NUM_SRC-1:0]  mask;
  logic [SRC_W-1:0]    ptr;
  logic [RC_W-1:0]     rst_cnt;

  logic                grant_vld;
  logic [SRC_W-1:0]    grant_idx;
  logic [NUM_SRC-1:0]  grant_oh;
  logic [CODE_W-1:0]   grant_code;
  logic [NUM_SRC-1:0]  mask_next;

  function automatic int wrap_idx(input int base, input int k);
    return (base + k) % NUM_SRC;
  endfunction

  // Round-robin search starting at the pointer; already-accepted sources are skipped.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    grant_vld = 1'b0;
    grant_idx = '0;
    if (state == S_RUN) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (!grant_vld && rpt_valid[wrap_idx(int'(ptr), k)] && !mask[wrap_idx(int'(ptr), k)]) begin
          grant_vld = 1'b1;
          grant_idx = SRC_W'(wrap_idx(int'(ptr), k));
        end
      end
    end
    grant_oh   = grant_vld ? (NUM_SRC'(1) << grant_idx) : '0;
    grant_code = rpt_code[grant_idx*CODE_W +: CODE_W];
    mask_next  = mask | grant_oh;
  end

  assign rpt_ready = grant_oh;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state       <= S_IDLE;
      dut_reset   <= 1'b1;
      mask        <= '0;
      ptr         <= '0;
      rst_cnt     <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      success     <= 1'b0;
      failure     <= 1'b0;
      reason      <= REASON_NONE;
      fail_src    <= '0;
      fail_code   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_RESET;
            rst_cnt     <= '0;
            cycle_count <= '0;
            mask        <= '0;
            ptr         <= '0;
          end
        end
        S_RESET: begin
          if (rst_cnt == RC_W'(RESET_CYCLES - 1)) begin
            state     <= S_RUN;
            dut_reset <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (grant_vld) begin
            mask <= mask_next;
            ptr  <= (int'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + 1'b1;
          end
          // A failing report outranks completion, which outranks the budget timeout.
          if (grant_vld && grant_code != '0) begin
            state     <= S_DONE;
            dut_reset <= 1'b1;
            done      <= 1'b1;
            failure   <= 1'b1;
            reason    <= REASON_FAIL;
            fail_src  <= grant_idx;
            fail_code <= grant_code;
          end else if (&mask_next) begin
            state     <= S_DONE;
            dut_reset <= 1'b1;
            done      <= 1'b1;
            success   <= 1'b1;
            reason    <= REASON_NONE;
          end else if (max_cycles != '0 && cycle_count >= max_cycles) begin
            state     <= S_DONE;
            dut_reset <= 1'b1;
            done      <= 1'b1;
            failure   <= 1'b1;
            reason    <= REASON_TIMEOUT;
          end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + 1'b1;
          end
        end
        S_DONE: begin
          dut_reset <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
